// File: rtl/ofdm_tx_pkg.sv
// Shared constants, FSM state type and the lane-wise IQ adder for the
// OFDM transmit frame scheduler.
package ofdm_tx_pkg;

    localparam int TRAIN_LEN = 320;
    localparam int SYM_LEN   = 80;
    localparam int IQ_W      = 8;
    localparam int SAMP_W    = 2 * IQ_W;
    localparam int IDX_W     = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRAIN,
        ST_SIGNAL,
        ST_DATA,
        ST_TAIL
    } tx_state_e;

    // I in the upper lane, Q in the lower lane; each lane wraps on its own.
    function automatic logic [SAMP_W-1:0] iq_add(input logic [SAMP_W-1:0] a,
                                                 input logic [SAMP_W-1:0] b);
        logic [IQ_W-1:0] i_sum;
        logic [IQ_W-1:0] q_sum;
        i_sum = a[SAMP_W-1:IQ_W] + b[SAMP_W-1:IQ_W];
        q_sum = a[IQ_W-1:0] + b[IQ_W-1:0];
        return {i_sum, q_sum};
    endfunction

endpackage

// File: rtl/tx_out_stage.sv
// Single-entry registered AXIS slice toward the DAC FIFO. Carries sample,
// last, sof and index. up_en_o tells the scheduler the slice can take a
// new beat this cycle (empty, or draining downstream).
module tx_out_stage
    import ofdm_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld_i,
    input  logic [SAMP_W-1:0] in_data_i,
    input  logic              in_last_i,
    input  logic              in_sof_i,
    input  logic [IDX_W-1:0]  in_index_i,
    output logic              up_en_o,
    input  logic              out_rdy_i,
    output logic              out_vld_o,
    output logic [SAMP_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              out_sof_o,
    output logic [IDX_W-1:0]  out_index_o
);

    logic              vld_q;
    logic [SAMP_W-1:0] data_q;
    logic              last_q;
    logic              sof_q;
    logic [IDX_W-1:0]  index_q;

    assign up_en_o = !vld_q || out_rdy_i;

    // Load a new beat only when the slot is free; payload freezes while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sof_q   <= 1'b0;
            index_q <= '0;
        end else if (up_en_o) begin
            vld_q <= in_vld_i;
            if (in_vld_i) begin
                data_q  <= in_data_i;
                last_q  <= in_last_i;
                sof_q   <= in_sof_i;
                index_q <= in_index_i;
            end
        end
    end

    assign out_vld_o   = vld_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign out_sof_o   = sof_q;
    assign out_index_o = index_q;

endmodule

// File: rtl/ofdm_tx_frame_sched.sv
// OFDM transmit frame scheduler: training preamble, SIGNAL symbol and nsym
// DATA symbols, with a one-sample overlap-add window at each boundary.
// Handshake: a beat moves on any interface exactly in a cycle where its
// valid and ready are both high at the rising clock edge; ready never
// waits on valid, and a source only sees ready while its segment is active.
module ofdm_tx_frame_sched #(
    parameter int TRAIN_LEN = 320,
    parameter int SYM_LEN   = 80,
    parameter int NSYM_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NSYM_W-1:0] nsym,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    input  logic [15:0]       train_din,
    input  logic              train_din_vld,
    input  logic              train_din_last,
    output logic              train_dout_rdy,
    input  logic [15:0]       ifft_din,
    input  logic              ifft_din_vld,
    input  logic              ifft_din_last,
    output logic              ifft_dout_rdy,
    input  logic              dac_din_rdy,
    output logic [15:0]       dac_dout,
    output logic              dac_dout_vld,
    output logic              dac_dout_last,
    output logic              dac_dout_sof,
    output logic [8:0]        dac_dout_Index
);
    import ofdm_tx_pkg::*;

    tx_state_e         state_q;
    logic [IDX_W-1:0]  scnt_q;
    logic [NSYM_W-1:0] nsym_q;
    logic [NSYM_W-1:0] symcnt_q;
    logic [SAMP_W-1:0] hold_q;
    logic              busy_q;
    logic              len_err_q;
    logic              tail_sent_q;

    logic              up_en;
    logic              in_train;
    logic              in_sym;
    logic              src_vld;
    logic              src_last;
    logic [SAMP_W-1:0] src_data;
    logic              src_acc;
    logic              seg_end;
    logic              st_vld;
    logic              st_last;
    logic              st_sof;
    logic [SAMP_W-1:0] st_data;
    logic [IDX_W-1:0]  st_idx;

    assign in_train       = (state_q == ST_TRAIN);
    assign in_sym         = (state_q == ST_SIGNAL) || (state_q == ST_DATA);
    assign train_dout_rdy = in_train && up_en;
    assign ifft_dout_rdy  = in_sym && up_en;

    // Steer the active source onto a common sample path.
    always_comb begin
        src_vld  = 1'b0;
        src_last = 1'b0;
        src_data = '0;
        if (in_train) begin
            src_vld  = train_din_vld;
            src_last = train_din_last;
            src_data = train_din;
        end else if (in_sym) begin
            src_vld  = ifft_din_vld;
            src_last = ifft_din_last;
            src_data = ifft_din;
        end
    end

    assign src_acc = src_vld && (train_dout_rdy || ifft_dout_rdy);
    assign seg_end = in_train ? (scnt_q == IDX_W'(TRAIN_LEN - 1))
                              : (scnt_q == IDX_W'(SYM_LEN - 1));

    // Window mux: the segment's last sample is parked in hold_q and merged
    // into the next segment's first sample; TAIL flushes it alone.
    always_comb begin
        st_vld  = 1'b0;
        st_data = src_data;
        st_last = 1'b0;
        st_sof  = 1'b0;
        st_idx  = scnt_q;
        if (state_q == ST_TAIL) begin
            st_vld  = !tail_sent_q;
            st_data = hold_q;
            st_last = 1'b1;
            st_idx  = IDX_W'(SYM_LEN - 1);
        end else begin
            st_vld = src_acc && !seg_end;
            st_sof = in_train && (scnt_q == '0);
            if (in_sym && (scnt_q == '0)) begin
                st_data = iq_add(hold_q, src_data);
            end
        end
    end

    // Frame FSM with sample/symbol counters, hold register and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            scnt_q      <= '0;
            nsym_q      <= '0;
            symcnt_q    <= '0;
            hold_q      <= '0;
            busy_q      <= 1'b0;
            len_err_q   <= 1'b0;
            tail_sent_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_TRAIN;
                        nsym_q      <= nsym;
                        scnt_q      <= '0;
                        symcnt_q    <= '0;
                        busy_q      <= 1'b1;
                        len_err_q   <= 1'b0;
                        tail_sent_q <= 1'b0;
                    end
                end
                ST_TRAIN, ST_SIGNAL, ST_DATA: begin
                    if (src_acc) begin
                        if (seg_end) begin
                            scnt_q <= '0;
                            hold_q <= src_data;
                            if (!src_last) len_err_q <= 1'b1;
                            case (state_q)
                                ST_TRAIN: state_q <= ST_SIGNAL;
                                ST_SIGNAL: begin
                                    symcnt_q <= '0;
                                    state_q  <= (nsym_q == '0) ? ST_TAIL : ST_DATA;
                                end
                                ST_DATA: begin
                                    if ((symcnt_q + NSYM_W'(1)) < nsym_q) begin
                                        symcnt_q <= symcnt_q + NSYM_W'(1);
                                    end else begin
                                        state_q <= ST_TAIL;
                                    end
                                end
                                default: state_q <= ST_IDLE;
                            endcase
                        end else begin
                            scnt_q <= scnt_q + IDX_W'(1);
                            if (src_last) len_err_q <= 1'b1;
                        end
                    end
                end
                ST_TAIL: begin
                    if (up_en && !tail_sent_q) tail_sent_q <= 1'b1;
                    if (done) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        tail_sent_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign len_err = len_err_q;
    assign done    = dac_dout_vld && dac_dout_last && dac_din_rdy;

    tx_out_stage u_out (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_vld_i    (st_vld),
        .in_data_i   (st_data),
        .in_last_i   (st_last),
        .in_sof_i    (st_sof),
        .in_index_i  (st_idx),
        .up_en_o     (up_en),
        .out_rdy_i   (dac_din_rdy),
        .out_vld_o   (dac_dout_vld),
        .out_data_o  (dac_dout),
        .out_last_o  (dac_dout_last),
        .out_sof_o   (dac_dout_sof),
        .out_index_o (dac_dout_Index)
    );

endmodule

// File: tb/tb_ofdm_tx_frame_sched.sv
// Bench for ofdm_tx_frame_sched: table of frame scenarios checked against a
// frame-level expected queue, plus a hand-written mid-frame reset sequence.
module tb_ofdm_tx_frame_sched;

    localparam int TRAIN_LEN = 320;
    localparam int SYM_LEN   = 80;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [7:0]  nsym = '0;
    logic        busy, done, len_err;
    logic [15:0] train_din = '0;
    logic        train_din_vld = 1'b0, train_din_last = 1'b0;
    logic        train_dout_rdy;
    logic [15:0] ifft_din = '0;
    logic        ifft_din_vld = 1'b0, ifft_din_last = 1'b0;
    logic        ifft_dout_rdy;
    logic        dac_din_rdy = 1'b0;
    logic [15:0] dac_dout;
    logic        dac_dout_vld, dac_dout_last, dac_dout_sof;
    logic [8:0]  dac_dout_Index;

    ofdm_tx_frame_sched dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .nsym           (nsym),
        .busy           (busy),
        .done           (done),
        .len_err        (len_err),
        .train_din      (train_din),
        .train_din_vld  (train_din_vld),
        .train_din_last (train_din_last),
        .train_dout_rdy (train_dout_rdy),
        .ifft_din       (ifft_din),
        .ifft_din_vld   (ifft_din_vld),
        .ifft_din_last  (ifft_din_last),
        .ifft_dout_rdy  (ifft_dout_rdy),
        .dac_din_rdy    (dac_din_rdy),
        .dac_dout       (dac_dout),
        .dac_dout_vld   (dac_dout_vld),
        .dac_dout_last  (dac_dout_last),
        .dac_dout_sof   (dac_dout_sof),
        .dac_dout_Index (dac_dout_Index)
    );

    // ---------------- scenario table ----------------
    typedef struct {
        int nsym;
        int mode;        // 0: constant 0x0101/0x0202, 1: random, 2: random + overflow pair
        int rdy_pct;
        int err_pos;     // ifft stream index with a stray last, -1 none
        int start_pos;   // ifft stream index at which start is re-pulsed, -1 none
        int start_nsym;
        bit start_at_tail;
        int exp_cnt;
        bit exp_err;
    } vec_t;

    vec_t vecs[6];

    // ---------------- scoreboard state ----------------
    logic [26:0] exp_q[$];
    logic [15:0] tmem[512];
    logic        tlast[512];
    logic [15:0] imem[1024];
    logic        ilast[1024];
    logic [26:0] got_mem[1024];
    logic [26:0] stall_val, fb_got, fb_exp;
    int tp, ip, itot, got_n, mism, extra, done_cnt, stall_err, fb_idx;
    int rdy_pct, start_pos, start_nsym;
    bit start_at_tail, mid_start_done, stall_pend;
    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] lane_add(input logic [15:0] a, input logic [15:0] b);
        logic [7:0] i_s, q_s;
        i_s = a[15:8] + b[15:8];
        q_s = a[7:0] + b[7:0];
        return {i_s, q_s};
    endfunction

    task automatic fill(input int mode, input int n, input int err_pos);
        for (int i = 0; i < 512; i++) begin
            tmem[i]  = (mode == 0) ? 16'h0101 : 16'($urandom);
            tlast[i] = (i == TRAIN_LEN - 1);
        end
        for (int i = 0; i < 1024; i++) begin
            imem[i]  = (mode == 0) ? 16'h0202 : 16'($urandom);
            ilast[i] = ((i % SYM_LEN) == SYM_LEN - 1);
        end
        if (mode == 2) begin
            tmem[TRAIN_LEN-1] = 16'h7F80;
            imem[0]           = 16'h0190;
        end
        if (err_pos >= 0) ilast[err_pos] = 1'b1;
        itot = (n + 1) * SYM_LEN;
        tp = 0;
        ip = 0;
    endtask

    // Expected frame: {last, sof, index, sample} per output beat.
    task automatic build_exp(input int n);
        logic [15:0] prev;
        exp_q.delete();
        for (int i = 0; i < TRAIN_LEN - 1; i++)
            exp_q.push_back({1'b0, (i == 0), 9'(i), tmem[i]});
        prev = tmem[TRAIN_LEN-1];
        for (int k = 0; k <= n; k++) begin
            exp_q.push_back({1'b0, 1'b0, 9'd0, lane_add(prev, imem[k*SYM_LEN])});
            for (int j = 1; j < SYM_LEN - 1; j++)
                exp_q.push_back({1'b0, 1'b0, 9'(j), imem[k*SYM_LEN + j]});
            prev = imem[k*SYM_LEN + SYM_LEN - 1];
        end
        exp_q.push_back({1'b1, 1'b0, 9'(SYM_LEN - 1), prev});
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle();
        logic [26:0] out_w, e;
        @(negedge clk);
        start = 1'b0;
        if (start_pos >= 0 && !mid_start_done && ip == start_pos) begin
            start = 1'b1;
            nsym = 8'(start_nsym);
            mid_start_done = 1'b1;
        end
        if (start_at_tail && dac_dout_vld && dac_dout_last) begin
            start = 1'b1;
            nsym = 8'd3;
        end
        dac_din_rdy    = (int'($urandom_range(0, 99)) < rdy_pct);
        train_din_vld  = (tp < TRAIN_LEN);
        train_din      = tmem[tp];
        train_din_last = tlast[tp];
        ifft_din_vld   = (ip < itot);
        ifft_din       = imem[ip];
        ifft_din_last  = ilast[ip];
        #1;
        out_w = {dac_dout_last, dac_dout_sof, dac_dout_Index, dac_dout};
        if (stall_pend && (!dac_dout_vld || out_w !== stall_val)) stall_err++;
        stall_pend = dac_dout_vld && !dac_din_rdy;
        stall_val  = out_w;
        if (dac_dout_vld && dac_din_rdy) begin
            if (got_n < 1024) got_mem[got_n] = out_w;
            if (exp_q.size() == 0) extra++;
            else begin
                e = exp_q.pop_front();
                if (e !== out_w) begin
                    if (mism == 0) begin
                        fb_idx = got_n;
                        fb_got = out_w;
                        fb_exp = e;
                    end
                    mism++;
                end
            end
            got_n++;
        end
        if (done) done_cnt++;
        if (train_din_vld && train_dout_rdy) tp++;
        if (ifft_din_vld && ifft_dout_rdy) ip++;
    endtask

    task automatic run_frame(input int id, input vec_t v);
        int guard;
        fill(v.mode, v.nsym, v.err_pos);
        build_exp(v.nsym);
        got_n = 0; mism = 0; extra = 0; done_cnt = 0; stall_err = 0;
        stall_pend = 1'b0; mid_start_done = 1'b0;
        rdy_pct = v.rdy_pct; start_pos = v.start_pos; start_nsym = v.start_nsym;
        start_at_tail = v.start_at_tail;
        @(negedge clk);
        start = 1'b1;
        nsym = 8'(v.nsym);
        cycle();
        chk($sformatf("v%0d_busy_after_start", id), 32'(busy), 32'd1);
        chk($sformatf("v%0d_len_err_cleared", id), 32'(len_err), 32'd0);
        guard = 0;
        while (done_cnt == 0 && guard < 8000) begin
            cycle();
            guard++;
        end
        chk($sformatf("v%0d_frame_completes", id), 32'(done_cnt != 0), 32'd1);
        repeat (4) cycle();
        chk($sformatf("v%0d_out_count", id), 32'(got_n), 32'(v.exp_cnt));
        chk($sformatf("v%0d_data_mismatches", id), 32'(mism), 32'd0);
        if (mism != 0)
            $display("  v%0d first difference at beat %0d: got %h want %h", id, fb_idx, fb_got, fb_exp);
        chk($sformatf("v%0d_missing_or_extra", id), 32'(exp_q.size() + extra), 32'd0);
        chk($sformatf("v%0d_done_pulses", id), 32'(done_cnt), 32'd1);
        chk($sformatf("v%0d_stall_stability", id), 32'(stall_err), 32'd0);
        chk($sformatf("v%0d_idle_after", id), 32'({busy, dac_dout_vld}), 32'd0);
        chk($sformatf("v%0d_len_err", id), 32'(len_err), 32'(v.exp_err));
        if (v.mode == 0 && got_n == v.exp_cnt) begin
            chk($sformatf("v%0d_first_sof_idx", id), 32'(got_mem[0][25:16]), 32'({1'b1, 9'd0}));
            chk($sformatf("v%0d_merged_319", id), 32'(got_mem[319][24:0]), 32'({9'd0, 16'h0303}));
            chk($sformatf("v%0d_tail", id), 32'(got_mem[v.exp_cnt-1]), 32'({1'b1, 1'b0, 9'd79, 16'h0202}));
        end
        if (v.mode == 2 && got_n > 319)
            chk($sformatf("v%0d_overflow_merge", id), 32'(got_mem[319][15:0]), 32'h8010);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int guard;
        vec_t clean;
        vecs[0] = '{0, 0, 100, -1, -1, 0, 1'b0, 399, 1'b0};
        vecs[1] = '{2, 1,  50, -1, -1, 0, 1'b0, 557, 1'b0};
        vecs[2] = '{0, 2, 100, -1, -1, 0, 1'b0, 399, 1'b0};
        vecs[3] = '{0, 0, 100, 40, -1, 0, 1'b0, 399, 1'b1};
        vecs[4] = '{1, 1,  70, -1, 120, 5, 1'b0, 478, 1'b0};
        vecs[5] = '{3, 1, 100, -1, -1, 0, 1'b1, 636, 1'b0};
        clean   = '{0, 0, 100, -1, -1, 0, 1'b0, 399, 1'b0};
        start_pos = -1; start_at_tail = 1'b0; rdy_pct = 100;
        fill(0, 0, -1);
        itot = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", 32'({busy, done, len_err, train_dout_rdy, ifft_dout_rdy,
                               dac_dout_vld, dac_dout_last, dac_dout_sof}), 32'd0);
        chk("reset_data", 32'({dac_dout_Index, dac_dout}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

        // Mid-frame asynchronous reset at TRAIN sample 100, with len_err already set.
        fill(0, 0, -1);
        tlast[50] = 1'b1;
        rdy_pct = 100; start_pos = -1; start_at_tail = 1'b0;
        @(negedge clk);
        start = 1'b1;
        nsym = 8'd0;
        guard = 0;
        while (tp < 100 && guard < 1000) begin
            cycle();
            guard++;
        end
        chk("rst_mid_reached_sample_100", 32'(tp), 32'd100);
        chk("rst_mid_len_err_before", 32'(len_err), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl_zero", 32'({busy, done, len_err, train_dout_rdy, ifft_dout_rdy,
                                      dac_dout_vld, dac_dout_last, dac_dout_sof}), 32'd0);
        chk("rst_mid_data_zero", 32'({dac_dout_Index, dac_dout}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(6, clean);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
